// File: rtl/legup_stub_pkg.sv
// Shared encodings and default widths for the LegUp accelerator stand-in.
package legup_stub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DEF_RET_W = 32;
   localparam int DEF_ARG_W = 8;

endpackage

// File: rtl/legup_top_stub.sv
// Board bring-up stand-in for the generated accelerator top: returns sum(1..N).
// Optional cycle counter output enabled by LEGUP_STUB_CYCLE_COUNT_EN.
module legup_top_stub
   import legup_stub_pkg::*;
#(
   parameter int RET_W = DEF_RET_W,
   parameter int ARG_W = DEF_ARG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [ARG_W-1:0] arg_in,
   output logic             finish,
   output logic [RET_W-1:0] return_val,
`ifdef LEGUP_STUB_CYCLE_COUNT_EN
   output logic [31:0]      cycles,
`endif
   output logic [3:0]       state
);

   state_t           st;
   logic [ARG_W-1:0] cnt;
   logic [RET_W-1:0] acc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st         <= IDLE;
         cnt        <= '0;
         acc        <= '0;
         finish     <= 1'b0;
         return_val <= '0;
      end else begin
         finish <= 1'b0;
         case (st)
            IDLE: begin
               if (start) begin
                  cnt <= arg_in;
                  acc <= '0;
                  st  <= LOAD;
               end
            end
            LOAD: st <= RUN;
            RUN: begin
               if (cnt != '0) begin
                  acc <= acc + RET_W'(cnt);
                  cnt <= cnt - ARG_W'(1);
               end else begin
                  // Result and pulse land together so they are visible in the DONE cycle.
                  return_val <= acc;
                  finish     <= 1'b1;
                  st         <= DONE;
               end
            end
            DONE:    st <= IDLE;
            default: st <= IDLE;
         endcase
      end
   end

   assign state = {2'b00, st};

`ifdef LEGUP_STUB_CYCLE_COUNT_EN
   // Counts the LOAD cycle as 1 so the value seen at finish spans start edge to DONE inclusive.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cycles <= '0;
      else if (st == IDLE && start)
         cycles <= 32'd1;
      else if (st == LOAD || st == RUN)
         cycles <= cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_legup_top_stub.sv
// Directed bench for legup_top_stub: latency, results, start handling and reset abort.
module tb_legup_top_stub;

   localparam int RET_W = 32;
   localparam int ARG_W = 8;

   logic             clk;
   logic             reset;
   logic             start;
   logic [ARG_W-1:0] arg_in;
   logic             finish;
   logic [RET_W-1:0] return_val;
   logic [3:0]       state;
`ifdef LEGUP_STUB_CYCLE_COUNT_EN
   logic [31:0]      cycles;
`endif

   int checks = 0;
   int errors = 0;

   legup_top_stub #(.RET_W(RET_W), .ARG_W(ARG_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .arg_in     (arg_in),
      .finish     (finish),
      .return_val (return_val),
`ifdef LEGUP_STUB_CYCLE_COUNT_EN
      .cycles     (cycles),
`endif
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one call and measures cycles to finish (lat=-1 on timeout); no checking here.
   task automatic do_call(input int n, output int lat, output logic [RET_W-1:0] rv);
      lat = -1;
      rv  = '0;
      @(negedge clk);
      start  = 1'b1;
      arg_in = ARG_W'(n);
      @(negedge clk);
      start  = 1'b0;
      arg_in = 8'hA5;
      for (int k = 1; k <= n + 50; k++) begin
         if (finish === 1'b1) begin
            lat = k;
            rv  = return_val;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset  = 1'b0;
      start  = 1'b0;
      arg_in = '0;
      repeat (2) @(negedge clk);
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", finish); end
      checks++; if (return_val !== 32'd0) begin errors++; $display("FAIL reset_rv got %0d want 0", return_val); end
`ifdef LEGUP_STUB_CYCLE_COUNT_EN
      checks++; if (cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles got %0d want 0", cycles); end
`endif
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      @(negedge clk);
      start  = 1'b1;
      arg_in = 8'd10;
      @(negedge clk);
      start  = 1'b0;
      arg_in = 8'd99;
      checks++; if (state !== 4'd1) begin errors++; $display("FAIL basic_load_state got %0d want 1", state); end
      @(negedge clk);
      checks++; if (state !== 4'd2) begin errors++; $display("FAIL basic_run_state got %0d want 2", state); end
      // Cycle 2 reached; DONE expected in cycle 13.
      repeat (11) @(negedge clk);
      checks++; if (finish !== 1'b1 || state !== 4'd3) begin errors++; $display("FAIL basic_finish_c13 got fin=%b st=%0d want fin=1 st=3", finish, state); end
      checks++; if (return_val !== 32'd55) begin errors++; $display("FAIL basic_rv got %0d want 55", return_val); end
      @(negedge clk);
      checks++; if (finish !== 1'b0 || state !== 4'd0) begin errors++; $display("FAIL basic_pulse_width got fin=%b st=%0d want fin=0 st=0", finish, state); end
      checks++; if (return_val !== 32'd55) begin errors++; $display("FAIL basic_rv_hold got %0d want 55", return_val); end
   endtask

   task automatic test_zero_and_max;
      int lat;
      logic [RET_W-1:0] rv;
      do_call(0, lat, rv);
      checks++; if (lat != 3) begin errors++; $display("FAIL zero_latency got %0d want 3", lat); end
      checks++; if (rv !== 32'd0) begin errors++; $display("FAIL zero_rv got %0d want 0", rv); end
      do_call(255, lat, rv);
      checks++; if (lat != 258) begin errors++; $display("FAIL max_latency got %0d want 258", lat); end
      checks++; if (rv !== 32'd32640) begin errors++; $display("FAIL max_rv got %0d want 32640", rv); end
   endtask

   task automatic test_ignore_start;
      int nfin = 0;
      int lat  = -1;
      logic [RET_W-1:0] rv = '0;
      @(negedge clk);
      start  = 1'b1;
      arg_in = 8'd10;
      @(negedge clk);
      start  = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         if (finish === 1'b1) begin
            nfin++;
            if (lat < 0) begin lat = k; rv = return_val; end
         end
         if (k == 4) begin
            checks++; if (return_val !== 32'd32640) begin errors++; $display("FAIL ignore_rv_stable got %0d want 32640", return_val); end
         end
         if (k == 5) begin start = 1'b1; arg_in = 8'd7; end
         if (k == 6) start = 1'b0;
         @(negedge clk);
      end
      checks++; if (nfin != 1) begin errors++; $display("FAIL ignore_finish_count got %0d want 1", nfin); end
      checks++; if (lat != 13) begin errors++; $display("FAIL ignore_latency got %0d want 13", lat); end
      checks++; if (rv !== 32'd55) begin errors++; $display("FAIL ignore_rv got %0d want 55", rv); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] mask = '0;
      logic [31:0] exp_mask;
      exp_mask = (32'd1 << 6) | (32'd1 << 13) | (32'd1 << 20);
      @(negedge clk);
      start  = 1'b1;
      arg_in = 8'd3;
      @(negedge clk);
      for (int k = 1; k <= 21; k++) begin
         if (finish === 1'b1) begin
            mask[k] = 1'b1;
            checks++; if (return_val !== 32'd6) begin errors++; $display("FAIL b2b_rv cyc %0d got %0d want 6", k, return_val); end
         end
         if (k == 21) start = 1'b0;
         @(negedge clk);
      end
      checks++; if (mask !== exp_mask) begin errors++; $display("FAIL b2b_finish_mask got %h want %h", mask, exp_mask); end
   endtask

   task automatic test_reset_mid_run;
      int nfin = 0;
      int lat;
      logic [RET_W-1:0] rv;
      @(negedge clk);
      start  = 1'b1;
      arg_in = 8'd20;
      @(negedge clk);
      start  = 1'b0;
      repeat (7) @(negedge clk);
      checks++; if (state !== 4'd2) begin errors++; $display("FAIL midrst_pre_state got %0d want 2", state); end
      reset = 1'b0;
      #1;
      checks++; if (state !== 4'd0 || finish !== 1'b0 || return_val !== 32'd0) begin
         errors++; $display("FAIL midrst_outputs got st=%0d fin=%b rv=%0d want 0/0/0", state, finish, return_val);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 30; k++) begin
         if (finish === 1'b1) nfin++;
         @(negedge clk);
      end
      checks++; if (nfin != 0) begin errors++; $display("FAIL midrst_no_finish got %0d want 0", nfin); end
      do_call(4, lat, rv);
      checks++; if (lat != 7) begin errors++; $display("FAIL midrst_new_latency got %0d want 7", lat); end
      checks++; if (rv !== 32'd10) begin errors++; $display("FAIL midrst_new_rv got %0d want 10", rv); end
   endtask

`ifdef LEGUP_STUB_CYCLE_COUNT_EN
   task automatic test_cycle_count;
      int lat = -1;
      logic [31:0] cyc = '0;
      @(negedge clk);
      start  = 1'b1;
      arg_in = 8'd5;
      @(negedge clk);
      start  = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (finish === 1'b1) begin lat = k; cyc = cycles; break; end
         @(negedge clk);
      end
      checks++; if (lat != 8) begin errors++; $display("FAIL cyc_latency got %0d want 8", lat); end
      checks++; if (cyc !== 32'd8) begin errors++; $display("FAIL cyc_at_finish got %0d want 8", cyc); end
      repeat (5) @(negedge clk);
      checks++; if (cycles !== 32'd8) begin errors++; $display("FAIL cyc_hold got %0d want 8", cycles); end
   endtask
`endif

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      arg_in = '0;
      test_reset();
      test_basic();
      test_zero_and_max();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
`ifdef LEGUP_STUB_CYCLE_COUNT_EN
      test_cycle_count();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/legup_top_stub.md
LEGUP_TOP_STUB -- requirements
Module: legup_top_stub

Interface
REQ-001 The block SHALL have parameter RET_W, default 32, giving the return_val width.
REQ-002 The block SHALL have parameter ARG_W, default 8, giving the arg_in width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: call request, sampled in IDLE only.
REQ-006 The block SHALL have port arg_in, input, ARG_W bits: call argument N (board SW), sampled with start.
REQ-007 The block SHALL have port finish, output, 1 bit: single-cycle completion pulse.
REQ-008 The block SHALL have port return_val, output, RET_W bits: result of the call, held until the next accepted start.
REQ-009 The block SHALL have port state, output, 4 bits: current FSM state encoding, for board LEDs.

Function
REQ-010 The block SHALL be the responder end of the start/finish/return_val call protocol: a drop-in stand-in for the generated accelerator top during board bring-up.
REQ-011 The FSM SHALL have states IDLE=0, LOAD=1, RUN=2 and DONE=3; all other encodings are illegal and SHALL return to IDLE on the next edge.
REQ-012 IDLE: on start=1 the block SHALL capture arg_in into cnt, clear acc and go to LOAD; start=0 SHALL keep it in IDLE.
REQ-013 LOAD -> RUN unconditionally, one cycle.
REQ-014 RUN: each cycle while cnt!=0, acc <= acc + cnt and cnt <= cnt - 1; when cnt==0 the block SHALL go to DONE.
REQ-015 DONE: return_val <= acc, finish=1 for exactly this one cycle, then IDLE.
REQ-016 The computed result SHALL be N*(N+1)/2, zero-extended to RET_W; with ARG_W=8 the maximum is 32640, so no overflow occurs; acc SHALL wrap modulo 2^RET_W for larger ARG_W.
REQ-017 Latency SHALL be N+3 cycles from the start-sampling edge to the finish cycle (N=0: 3 cycles).
REQ-018 start asserted outside IDLE SHALL be ignored, with no queuing; start held high continuously SHALL cause back-to-back calls, one accepted per IDLE visit.
REQ-019 arg_in changes after capture SHALL NOT affect the running call.
REQ-020 return_val SHALL stay stable from the DONE cycle until the next DONE and SHALL NOT show intermediate acc values.
REQ-021 state SHALL equal the registered FSM encoding, zero-extended to 4 bits.

Reset
REQ-022 reset=0 SHALL asynchronously force: state IDLE, finish=0, return_val=0, acc=0, cnt=0.
REQ-023 Reset mid-call SHALL abort the call with no finish pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-024 With macro LEGUP_STUB_CYCLE_COUNT_EN defined, the block SHALL add output cycles [31:0]: a counter cleared on the accepted start, incremented every cycle up to and including DONE, and held afterwards; it SHALL reset to 0.
REQ-025 Without LEGUP_STUB_CYCLE_COUNT_EN, the cycles port and counter SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-026 The shared package legup_stub_pkg SHALL hold the state encodings (IDLE/LOAD/RUN/DONE) and the default RET_W/ARG_W constants.
REQ-027 The block SHALL be a single module; no sub-module is required.

Verification
REQ-028 Reset release, start pulse with arg_in=10 -> finish on cycle 13 after the start edge, return_val=55.
REQ-029 arg_in=0 -> finish after 3 cycles, return_val=0; arg_in=255 -> return_val=32640 after 258 cycles.
REQ-030 start re-pulsed during RUN with a different arg_in -> ignored; single finish with the original result.
REQ-031 start held high, arg_in=3 -> repeated finish pulses, each with return_val=6, exactly one cycle wide, separated by the IDLE cycle.
REQ-032 reset=0 for one cycle mid-RUN (arg_in=20) -> all outputs 0 immediately, no finish; a new start with arg_in=4 -> return_val=10.
REQ-033 With LEGUP_STUB_CYCLE_COUNT_EN, arg_in=5 -> cycles=8 at finish and held until the next accepted start.
